alu_sequencer: RTL

- Program-driven controller for the 8-bit registered ALU (4-bit opcode, internal accumulator, registered output).
- Holds a small instruction buffer loaded by a host. On `start`, issues one instruction per clock to the ALU and returns each result with its index.
- Drives a harmless NOP (ADD 0,0) whenever no instruction is issued, so the ALU accumulator is zero at the start of every run.
- Aborts a run on divide-by-zero.

---
 rtl/alu_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Issues a host-loaded instruction buffer to a registered 8-bit ALU, one slot per clock,
// and returns each ALU result tagged with its slot index two edges after issue.
module alu_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_prog_we,
  input  logic [AW-1:0] i_prog_addr,
  input  logic [19:0]   i_prog_data,
  input  logic          i_start,
  input  logic [AW:0]   i_len,
  output logic [3:0]    o_alu_sel,
  output logic [7:0]    o_alu_a,
  output logic [7:0]    o_alu_b,
  input  logic [7:0]    i_alu_out,
  output logic          o_res_valid,
  output logic [7:0]    o_res_data,
  output logic [AW-1:0] o_res_idx,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [3:0]  L_DIV   = 4'b0011;

  state_t        r_state;
  state_t        w_next;
  logic [19:0]   r_mem [DEPTH];
  logic [AW:0]   r_n;
  logic [AW:0]   r_ptr;
  logic [3:0]    r_sel;
  logic [7:0]    r_a;
  logic [7:0]    r_b;
  logic          r_s1_vld;
  logic          r_s2_vld;
  logic [AW-1:0] r_s1_idx;
  logic [AW-1:0] r_s2_idx;
  logic          r_res_vld;
  logic [7:0]    r_res_data;
  logic [AW-1:0] r_res_idx;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic [AW:0]   w_len_clamped;
  logic [19:0]   w_instr;
  logic          w_div0;
  logic          w_last;
  logic          w_accept;
  logic          w_issue;
  logic          w_abort;

  assign w_len_clamped = (i_len > L_DEPTH) ? L_DEPTH : i_len;
  assign w_instr       = r_mem[r_ptr[AW-1:0]];
  assign w_div0        = (w_instr[19:16] == L_DIV) && (w_instr[7:0] == 8'd0);
  assign w_last        = (r_ptr == r_n - (AW+1)'(1));

  // Buffer has no reset; host writes are locked out only while a run is active.
  always_ff @(posedge i_clk) begin
    if (i_prog_we && !r_busy) begin
      r_mem[i_prog_addr] <= i_prog_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = (w_len_clamped == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (w_div0 || w_last) w_next = S_DRAIN;
      S_DRAIN: if (!r_s1_vld) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_issue  = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      S_IDLE:  w_accept = i_start;
      S_ISSUE: begin
        w_issue = !w_div0;
        w_abort = w_div0;
      end
      default: ;
    endcase
  end

  // Anything not issued becomes ADD 0,0, which also zeroes the ALU accumulator.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_n        <= '0;
      r_ptr      <= '0;
      r_sel      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_s1_vld   <= 1'b0;
      r_s2_vld   <= 1'b0;
      r_s1_idx   <= '0;
      r_s2_idx   <= '0;
      r_res_vld  <= 1'b0;
      r_res_data <= '0;
      r_res_idx  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_n   <= w_len_clamped;
        r_ptr <= '0;
      end else if (w_issue) begin
        r_ptr <= r_ptr + (AW+1)'(1);
      end
      r_sel    <= w_issue ? w_instr[19:16] : 4'd0;
      r_a      <= w_issue ? w_instr[15:8]  : 8'd0;
      r_b      <= w_issue ? w_instr[7:0]   : 8'd0;
      r_s1_vld <= w_issue;
      r_s1_idx <= r_ptr[AW-1:0];
      r_s2_vld <= r_s1_vld;
      r_s2_idx <= r_s1_idx;
      // ALU output at this edge belongs to the instruction issued two edges ago.
      r_res_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_res_data <= i_alu_out;
        r_res_idx  <= r_s2_idx;
      end
      r_busy <= (w_next == S_ISSUE) || (w_next == S_DRAIN);
      r_done <= (w_next == S_DONE);
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_alu_sel   = r_sel;
  assign o_alu_a     = r_a;
  assign o_alu_b     = r_b;
  assign o_res_valid = r_res_vld;
  assign o_res_data  = r_res_data;
  assign o_res_idx   = r_res_idx;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule
